// File: rtl/dds_wave_gen_if.sv
// Configuration port of the DDS waveform generator: a valid/ready word
// carrying mode, tuning word, amplitude, offset and square duty threshold.
interface dds_wave_gen_if #(
  parameter int DW = 14,
  parameter int PW = 32
) ();

  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_mode;
  logic [PW-1:0] cfg_ftw;
  logic [DW-1:0] cfg_amp;
  logic [DW-1:0] cfg_offset;
  logic [DW-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_ftw,
    output cfg_amp,
    output cfg_offset,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_ftw,
    input  cfg_amp,
    input  cfg_offset,
    input  cfg_duty,
    output cfg_ready
  );

endinterface

// File: rtl/dds_wave_gen.sv
// DDS waveform generator for DAC channel A.
// A PW-bit phase accumulator feeds saw, triangle, square, sine-LUT and DC
// sources. The chosen source is amplitude-scaled, offset, saturated and
// registered onto the DAC bus. New configuration words are held in a shadow
// copy while running and only swapped in at a phase wrap, so a waveform
// period is never cut short by a parameter change.
module dds_wave_gen #(
  parameter int DW  = 14,
  parameter int PW  = 32,
  parameter int LAW = 10
) (
  input  logic          clk,
  input  logic          rst,
  dds_wave_gen_if.slave cfg,
  output logic          active,
  output logic          wrap,
  output logic [DW-1:0] DA_A,
  output logic          DA_CLK_A,
  output logic          DA_WR_A
);

  localparam logic [2:0] MODE_SAW  = 3'd0;
  localparam logic [2:0] MODE_TRI  = 3'd1;
  localparam logic [2:0] MODE_SQR  = 3'd2;
  localparam logic [2:0] MODE_SINE = 3'd3;
  localparam logic [2:0] MODE_DC   = 3'd4;
  localparam logic [2:0] MODE_STOP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]    mode;
    logic [PW-1:0] ftw;
    logic [DW-1:0] amp;
    logic [DW-1:0] offset;
    logic [DW-1:0] duty;
  } cfg_t;

  localparam cfg_t RESET_CFG = '{mode: MODE_STOP, ftw: '0, amp: '0, offset: '0, duty: '0};

  // ---------------------------------------------------------------------
  // Sine table, built at elaboration time with integer-only arithmetic so
  // the ROM contents are the same for every tool. A quarter wave is
  // evaluated with a Taylor series in Q30 fixed point and mirrored into
  // the other three quadrants, which keeps the table exactly symmetric.
  // Values are offset-binary around midscale with peak +/-(2^(DW-1)-1).
  // ---------------------------------------------------------------------
  localparam longint PI_Q30   = 64'sd3373259426;
  localparam longint MID      = longint'(1) << (DW - 1);
  localparam longint HALF_AMP = MID - 1;

  function automatic logic [DW-1:0] sine_entry(input int idx);
    longint     quarter;
    longint     r;
    longint     k;
    longint     x;
    longint     x2;
    longint     term;
    longint     acc;
    longint     mag;
    logic [1:0] quad;
    quarter = longint'(1) << (LAW - 2);
    quad    = 2'(idx >> (LAW - 2));
    r       = longint'(idx) & (quarter - 1);
    k       = quad[0] ? (quarter - r) : r;
    x       = (k * PI_Q30) >>> (LAW - 1);
    x2      = (x * x) >>> 30;
    term    = x;
    acc     = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    mag = (acc * HALF_AMP + (longint'(1) << 29)) >>> 30;
    if (mag > HALF_AMP) mag = HALF_AMP;
    if (mag < 0) mag = 0;
    return quad[1] ? DW'(MID - mag) : DW'(MID + mag);
  endfunction

  logic [DW-1:0] sine_rom [2**LAW];

  for (genvar g = 0; g < 2**LAW; g++) begin : g_rom
    localparam logic [DW-1:0] ENTRY = sine_entry(g);
    assign sine_rom[g] = ENTRY;
  end

  // ---------------------------------------------------------------------
  // Control state and configuration registers
  // ---------------------------------------------------------------------
  state_t        state_q;
  state_t        state_d;
  cfg_t          act_q;
  cfg_t          shadow_q;
  cfg_t          cfg_in;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_sum;
  logic          carry;
  logic          accept;
  logic          apply_pend;

  assign cfg_in = '{mode: cfg.cfg_mode, ftw: cfg.cfg_ftw, amp: cfg.cfg_amp,
                    offset: cfg.cfg_offset, duty: cfg.cfg_duty};

  assign accept             = cfg.cfg_valid && cfg.cfg_ready;
  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, act_q.ftw};

  // A pending word is swapped in on a carry edge; with a zero tuning word
  // there will never be a carry, so it is swapped in on the next edge.
  assign apply_pend = (state_q == PEND) && (carry || (act_q.ftw == '0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode: start from IDLE, defer updates through PEND
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (cfg.cfg_mode == MODE_STOP) ? IDLE : RUN;
      RUN:  if (accept) state_d = PEND;
      PEND: if (apply_pend) state_d = (shadow_q.mode == MODE_STOP) ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs: no new word is taken while one is pending
  always_comb begin
    cfg.cfg_ready = (state_q != PEND);
    active        = (state_q == RUN) || (state_q == PEND);
  end

  // Phase accumulator, wrap pulse and active/shadow configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      wrap     <= 1'b0;
      act_q    <= RESET_CFG;
      shadow_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          phase_q <= '0;
          wrap    <= 1'b0;
          if (accept) act_q <= cfg_in;
        end
        RUN: begin
          phase_q <= phase_sum;
          wrap    <= carry;
          if (accept) shadow_q <= cfg_in;
        end
        PEND: begin
          wrap <= carry;
          if (apply_pend) begin
            act_q   <= shadow_q;
            phase_q <= (shadow_q.mode == MODE_STOP) ? '0 : phase_sum;
          end else begin
            phase_q <= phase_sum;
          end
        end
        default: begin
          phase_q <= '0;
          wrap    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: waveform sources. The sine ROM has a synchronous read, so the
  // arithmetic sources are registered alongside it; the select between the
  // two happens after the register. amp/offset ride with the sample.
  // ---------------------------------------------------------------------
  logic [DW-1:0]  t;
  logic [DW-1:0]  t2;
  logic [LAW-1:0] lut_addr;
  logic [DW-1:0]  src_d;
  logic           sel_sine_d;

  logic [DW-1:0]  src_s2;
  logic [DW-1:0]  lut_s2;
  logic           sel_sine_s2;
  logic [DW-1:0]  amp_s2;
  logic [DW-1:0]  off_s2;

  assign t        = phase_q[PW-1 -: DW];
  assign t2       = {t[DW-2:0], 1'b0};
  assign lut_addr = phase_q[PW-1 -: LAW];

  // Arithmetic waveform source for the current phase and active mode
  always_comb begin
    src_d      = '0;
    sel_sine_d = 1'b0;
    case (act_q.mode)
      MODE_SAW:  src_d = t;
      MODE_TRI:  src_d = phase_q[PW-1] ? ~t2 : t2;
      MODE_SQR:  src_d = (t < act_q.duty) ? '1 : '0;
      MODE_SINE: sel_sine_d = 1'b1;
      MODE_DC:   src_d = '1;
      default:   src_d = '0;
    endcase
    if (state_q == IDLE) begin
      src_d      = '0;
      sel_sine_d = 1'b0;
    end
  end

  // Source register and synchronous sine ROM read
  always_ff @(posedge clk) begin
    if (rst) begin
      src_s2      <= '0;
      lut_s2      <= '0;
      sel_sine_s2 <= 1'b0;
      amp_s2      <= '0;
      off_s2      <= '0;
    end else begin
      src_s2      <= src_d;
      lut_s2      <= sine_rom[lut_addr];
      sel_sine_s2 <= sel_sine_d;
      amp_s2      <= act_q.amp;
      off_s2      <= act_q.offset;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: amplitude scaling. Full 2*DW-bit product, upper half kept, so
  // an amp of all-ones is just under unity gain.
  // ---------------------------------------------------------------------
  logic [DW-1:0]   wave_s2;
  logic [2*DW-1:0] product;
  logic [DW-1:0]   scaled_s3;
  logic [DW-1:0]   off_s3;

  assign wave_s2 = sel_sine_s2 ? lut_s2 : src_s2;
  assign product = {{DW{1'b0}}, wave_s2} * {{DW{1'b0}}, amp_s2};

  // Scaled sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      scaled_s3 <= '0;
      off_s3    <= '0;
    end else begin
      scaled_s3 <= DW'(product >> DW);
      off_s3    <= off_s2;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 4: offset with saturation at full scale, onto the DAC bus
  // ---------------------------------------------------------------------
  logic [DW:0] sum;

  assign sum = {1'b0, scaled_s3} + {1'b0, off_s3};

  // DAC output register
  always_ff @(posedge clk) begin
    if (rst) DA_A <= '0;
    else     DA_A <= sum[DW] ? '1 : sum[DW-1:0];
  end

  // The DAC latches on the falling edge, mid-way through the data eye
  assign DA_CLK_A = clk;
  assign DA_WR_A  = ~clk;

endmodule
